// File: rtl/nco_pkg.sv
// Shared constants, quadrant type and quarter-wave table generator for the quadrature NCO.
package nco_pkg;

    localparam int unsigned NCO_AW = 32;
    localparam int unsigned NCO_PW = 12;
    localparam int unsigned NCO_OW = 16;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // T[k] = round((2^ow - 1) * sin(2*pi*(2k+1) / 2^(pw+1))), evaluated at elaboration
    function automatic logic [31:0] qw_entry(input int unsigned k,
                                             input int unsigned pw,
                                             input int unsigned ow);
        real amp;
        real ang;
        amp = real'((64'd1 << ow) - 64'd1);
        ang = 2.0 * 3.14159265358979323846 * real'(2 * k + 1) / real'(64'd1 << (pw + 1));
        return 32'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

endpackage

// File: rtl/quarter_wave_table.sv
// Dual-read synchronous quarter-wave sine ROM, one registered read per port.
module quarter_wave_table
    import nco_pkg::*;
#(
    parameter int unsigned PW = NCO_PW,
    parameter int unsigned OW = NCO_OW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [PW-3:0] i_addr_a,
    input  logic [PW-3:0] i_addr_b,
    output logic [OW-1:0] o_data_a,
    output logic [OW-1:0] o_data_b
);

    localparam int unsigned DEPTH = 32'd1 << (PW - 2);

    logic [OW-1:0] rom [DEPTH];
    logic [OW-1:0] data_a_q, data_a_d;
    logic [OW-1:0] data_b_q, data_b_d;

    // Constant table contents built from the package generator
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rom
        assign rom[g] = OW'(qw_entry(32'(g), PW, OW));
    end

    // Read ports advance only on enabled cycles
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (i_ce) begin
            data_a_d = rom[i_addr_a];
            data_b_d = rom[i_addr_b];
        end
    end

    // Read data registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign o_data_a = data_a_q;
    assign o_data_b = data_b_q;

endmodule

// File: rtl/quadrature_nco.sv
// Quadrature NCO: handshaked frequency load, phase accumulator, shared quarter-wave sin/cos lookup.
module quadrature_nco
    import nco_pkg::*;
#(
    parameter int unsigned AW = NCO_AW,
    parameter int unsigned PW = NCO_PW,
    parameter int unsigned OW = NCO_OW
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic [AW-1:0]     i_freq,
    input  logic              i_freq_valid,
    output logic              o_freq_ready,
    input  logic [PW-1:0]     i_phase_offset,
    input  logic              i_sync,
    output logic signed [OW:0] o_i,
    output logic signed [OW:0] o_q,
    output logic              o_valid
);

    localparam int unsigned KW = PW - 2;

    logic [AW-1:0]      acc_q, acc_d;
    logic [AW-1:0]      freq_q, freq_d;
    logic [AW-1:0]      hold_q, hold_d;
    logic               ready_q, ready_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic               neg_s_q, neg_s_d;
    logic               neg_c_q, neg_c_d;
    logic signed [OW:0] sin_q, sin_d;
    logic signed [OW:0] cos_q, cos_d;
    logic [2:0]         vsr_q, vsr_d;
    logic               valid_q, valid_d;

    logic [PW-1:0]      phase_cos;
    quadrant_e          quad_s, quad_c;
    logic [KW-1:0]      idx_s, idx_c;
    logic [OW-1:0]      mag_s, mag_c;
    logic signed [OW:0] ext_s, ext_c;

    // Quadrant decode: odd quadrants read the table mirrored, the lower half-circle is negated
    always_comb begin
        phase_cos = phase_q + PW'(32'd1 << (PW - 2));
        quad_s    = quadrant_e'(phase_q[PW-1 -: 2]);
        quad_c    = quadrant_e'(phase_cos[PW-1 -: 2]);
        idx_s     = (quad_s == Q1 || quad_s == Q3) ? ~phase_q[KW-1:0]   : phase_q[KW-1:0];
        idx_c     = (quad_c == Q1 || quad_c == Q3) ? ~phase_cos[KW-1:0] : phase_cos[KW-1:0];
        ext_s     = $signed({1'b0, mag_s});
        ext_c     = $signed({1'b0, mag_c});
    end

    quarter_wave_table #(
        .PW (PW),
        .OW (OW)
    ) u_table (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_addr_a  (idx_s),
        .i_addr_b  (idx_c),
        .o_data_a  (mag_s),
        .o_data_b  (mag_c)
    );

    // Next-state: frequency handshake runs every cycle, datapath only when enabled
    always_comb begin
        acc_d   = acc_q;
        freq_d  = freq_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        phase_d = phase_q;
        neg_s_d = neg_s_q;
        neg_c_d = neg_c_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        vsr_d   = vsr_q;

        if (!ready_q && i_ce) begin
            freq_d  = hold_q;
            ready_d = 1'b1;
        end else if (ready_q && i_freq_valid) begin
            hold_d  = i_freq;
            ready_d = 1'b0;
        end

        if (i_ce) begin
            acc_d   = i_sync ? '0 : acc_q + freq_q;
            phase_d = acc_q[AW-1 -: PW] + i_phase_offset;
            neg_s_d = (quad_s == Q2) || (quad_s == Q3);
            neg_c_d = (quad_c == Q2) || (quad_c == Q3);
            sin_d   = neg_s_q ? -ext_s : ext_s;
            cos_d   = neg_c_q ? -ext_c : ext_c;
            vsr_d   = {vsr_q[1:0], 1'b1};
        end

        valid_d = i_ce & vsr_d[2];
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q   <= '0;
            freq_q  <= '0;
            hold_q  <= '0;
            ready_q <= 1'b1;
            phase_q <= '0;
            neg_s_q <= 1'b0;
            neg_c_q <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
            vsr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            phase_q <= phase_d;
            neg_s_q <= neg_s_d;
            neg_c_q <= neg_c_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            vsr_q   <= vsr_d;
            valid_q <= valid_d;
        end
    end

    assign o_freq_ready = ready_q;
    assign o_q          = sin_q;
    assign o_i          = cos_q;
    assign o_valid      = valid_q;

endmodule

// File: tb/tb_quadrature_nco.sv
// Self-checking bench for quadrature_nco: literal vectors plus a golden-model scoreboard.
module tb_quadrature_nco;

    localparam int unsigned AW = 32;
    localparam int unsigned PW = 12;
    localparam int unsigned OW = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_ce = 1'b0;
    logic [AW-1:0]       i_freq = '0;
    logic                i_freq_valid = 1'b0;
    logic                o_freq_ready;
    logic [PW-1:0]       i_phase_offset = '0;
    logic                i_sync = 1'b0;
    logic signed [OW:0]  o_i;
    logic signed [OW:0]  o_q;
    logic                o_valid;

    quadrature_nco #(.AW(AW), .PW(PW), .OW(OW)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_ce           (i_ce),
        .i_freq         (i_freq),
        .i_freq_valid   (i_freq_valid),
        .o_freq_ready   (o_freq_ready),
        .i_phase_offset (i_phase_offset),
        .i_sync         (i_sync),
        .o_i            (o_i),
        .o_q            (o_q),
        .o_valid        (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int i;
    } samp_t;

    typedef struct {
        logic [PW-1:0] off;
        int            eq;
        int            ei;
    } vec_t;

    samp_t         sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] m_acc, m_freq, m_hold;
    logic          m_ready;
    int            m_en, m_vcnt;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gold_sin(input logic [PW-1:0] p);
        real amp, th, s;
        int  m;
        amp = (2.0 ** OW) - 1.0;
        th  = 2.0 * 3.14159265358979323846 * (2.0 * real'(p) + 1.0) / (2.0 ** (PW + 1));
        s   = $sin(th);
        m   = $rtoi(amp * ((s < 0.0) ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    function automatic samp_t golden(input logic [PW-1:0] p);
        samp_t         r;
        logic [PW-1:0] pc;
        pc  = p + PW'(1 << (PW - 2));
        r.q = gold_sin(p);
        r.i = gold_sin(pc);
        return r;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check #1 later
    task automatic cycle(input logic ce, input logic fv, input logic [AW-1:0] f,
                         input logic [PW-1:0] off, input logic sy);
        samp_t         e;
        logic [PW-1:0] p;
        i_ce = ce; i_freq_valid = fv; i_freq = f; i_phase_offset = off; i_sync = sy;
        @(posedge clk);
        if (ce) begin
            p = m_acc[AW-1 -: PW] + off;
            sb.push_back(golden(p));
            m_en++;
            m_acc = sy ? '0 : m_acc + m_freq;
        end
        if (!m_ready && ce) begin
            m_freq  = m_hold;
            m_ready = 1'b1;
        end else if (m_ready && fv) begin
            m_hold  = f;
            m_ready = 1'b0;
        end
        #1;
        chk("freq_ready", longint'(o_freq_ready), longint'(m_ready));
        chk("valid", longint'(o_valid), longint'(ce && m_en >= 3));
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_q", longint'(o_q), longint'(e.q));
                chk("sb_i", longint'(o_i), longint'(e.i));
                m_vcnt++;
            end
        end
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_o_i", longint'(o_i), 0);
        chk("rst_o_q", longint'(o_q), 0);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_ready", longint'(o_freq_ready), 1);
        m_acc = '0; m_freq = '0; m_hold = '0; m_ready = 1'b1;
        m_en = 0; m_vcnt = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[6];
        int   sq[4];
        int   si[4];
        int   en_snap;
        real  e2, a2;

        vecs[0] = '{off: 12'd0,    eq: 50,     ei: 65535};
        vecs[1] = '{off: 12'd1024, eq: 65535,  ei: -50};
        vecs[2] = '{off: 12'd2048, eq: -50,    ei: -65535};
        vecs[3] = '{off: 12'd3072, eq: -65535, ei: 50};
        vecs[4] = '{off: 12'd1023, eq: 65535,  ei: 50};
        vecs[5] = '{off: 12'd4095, eq: -50,    ei: 65535};
        sq = '{50, 65535, -50, -65535};
        si = '{65535, -50, -65535, 50};

        // Reset, then static phase 0 with freq 0
        apply_reset();
        repeat (4) cycle(1'b1, 1'b0, '0, '0, 1'b0);
        chk("freq0_q", longint'(o_q), 50);
        chk("freq0_i", longint'(o_i), 65535);
        repeat (2) cycle(1'b1, 1'b0, '0, '0, 1'b0);
        chk("freq0_q_rep", longint'(o_q), 50);
        chk("freq0_i_rep", longint'(o_i), 65535);

        // Offset table with freq 0: each offset held until it reaches the output
        for (int v = 0; v < 6; v++) begin
            repeat (3) cycle(1'b1, 1'b0, '0, vecs[v].off, 1'b0);
            chk($sformatf("vec%0d_q", v), longint'(o_q), longint'(vecs[v].eq));
            chk($sformatf("vec%0d_i", v), longint'(o_i), longint'(vecs[v].ei));
        end

        // Mid-stream reset, then quarter-rate tone
        apply_reset();
        cycle(1'b1, 1'b1, 32'h4000_0000, '0, 1'b0);
        for (int n = 2; n <= 12; n++) begin
            cycle(1'b1, 1'b0, '0, '0, 1'b0);
            if (n >= 5) begin
                chk($sformatf("tone_q_e%0d", n), longint'(o_q), longint'(sq[(n - 5) % 4]));
                chk($sformatf("tone_i_e%0d", n), longint'(o_i), longint'(si[(n - 5) % 4]));
            end
        end

        // Same tone with a quarter-turn offset
        apply_reset();
        cycle(1'b1, 1'b1, 32'h4000_0000, 12'd1024, 1'b0);
        for (int n = 2; n <= 12; n++) begin
            cycle(1'b1, 1'b0, '0, 12'd1024, 1'b0);
            if (n == 3) begin
                chk("off_first_q", longint'(o_q), 65535);
                chk("off_first_i", longint'(o_i), -50);
            end
            if (n >= 5) begin
                chk($sformatf("off_q_e%0d", n), longint'(o_q), longint'(sq[(n - 4) % 4]));
                chk($sformatf("off_i_e%0d", n), longint'(o_i), longint'(si[(n - 4) % 4]));
            end
        end

        // Handshake across a 5-cycle disabled gap: only the first request is captured
        cycle(1'b0, 1'b1, 32'h1000_0000, '0, 1'b0);
        chk("hs_ready_drop", longint'(o_freq_ready), 0);
        repeat (4) cycle(1'b0, 1'b1, 32'h2000_0000, '0, 1'b0);
        chk("hs_ready_gap", longint'(o_freq_ready), 0);
        chk("hs_valid_gap", longint'(o_valid), 0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        chk("hs_ready_back", longint'(o_freq_ready), 1);
        chk("hs_freq_applied", longint'(m_freq), longint'(32'h1000_0000));
        repeat (8) cycle(1'b1, 1'b0, '0, '0, 1'b0);

        // Sync colliding with a pending load on an enabled cycle
        cycle(1'b1, 1'b1, 32'h0800_0000, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        chk("sync_ready", longint'(o_freq_ready), 1);
        repeat (3) cycle(1'b1, 1'b0, '0, '0, 1'b0);
        chk("sync_q", longint'(o_q), 50);
        chk("sync_i", longint'(o_i), 65535);
        repeat (6) cycle(1'b1, 1'b0, '0, '0, 1'b0);

        // Random-enable sweep at one table step per enabled cycle
        apply_reset();
        cycle(1'b1, 1'b1, AW'(1) << (AW - PW), '0, 1'b0);
        a2 = ((2.0 ** OW) - 1.0) * ((2.0 ** OW) - 1.0);
        for (int c = 0; c < 6000; c++) begin
            cycle(1'(($urandom_range(0, 1))), 1'b0, '0, '0, 1'b0);
            if (o_valid) begin
                e2 = real'(o_q) * real'(o_q) + real'(o_i) * real'(o_i);
                chk("energy", longint'((e2 >= a2 * 0.999) && (e2 <= a2 * 1.001)), 1);
            end
        end
        en_snap = m_en;
        chk("sweep_valid_count", longint'(m_vcnt), longint'(en_snap - 2));
        chk("sweep_inflight", longint'(sb.size()), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
